bin2bcd_dabble: RTL and testbench



---
 rtl/bin2bcd_dabble.sv | 90 +++++++++
 tb/tb_bin2bcd_dabble.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Valid/ready handshakes on both sides; result digits are packed LSD-first.
module bin2bcd_dabble #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CW-1:0] LastCount = CW'(BIN_W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [BIN_W-1:0] shift_q;
    logic [BW-1:0]    scratch_q;

    logic [BW-1:0]    corr;
    logic [BW-1:0]    scratch_nxt;
    logic [BIN_W-1:0] shift_nxt;

    assign in_ready = (state_q == StIdle) & ~rst;

    // Add-3 correction on every digit, then shift the binary MSB into the scratch LSB.
    always_comb begin
        corr = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_nxt = {corr[BW-2:0], shift_q[BIN_W-1]};
        shift_nxt   = shift_q << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        count_q   <= '0;
                        busy      <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    scratch_q <= scratch_nxt;
                    shift_q   <= shift_nxt;
                    count_q   <= count_q + CW'(1);
                    if (count_q == LastCount) begin
                        bcd       <= scratch_nxt;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // bcd is left untouched so it stays readable until the next result.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_dabble.sv
// Scoreboard bench for bin2bcd_dabble: expected digits are queued on input acceptance
// and compared on each output handshake.
module tb_bin2bcd_dabble;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        busy;

    bit          use_rand;
    bit          ready_fix;
    bit          rnd_bit;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cycle    = 0;
    int          acc_edge = 0;
    bit          prev_ov  = 1'b0;
    logic [11:0] sb[$];
    int          rise_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    assign out_ready = use_rand ? rnd_bit : ready_fix;

    bin2bcd_dabble #(
        .BIN_W  (8),
        .DIGITS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Monitor: everything is sampled on the falling edge, i.e. what the next rising edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                sb.push_back(to_bcd(int'(bin)));
                acc_edge = cycle + 1;
            end
            if (out_valid && !prev_ov) begin
                check("latency", cycle - acc_edge, 8);
                rise_q.push_back(cycle);
            end
            if (out_valid && out_ready) begin
                check("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    logic [11:0] exp_v;
                    exp_v = sb.pop_front();
                    check("bcd", bcd, exp_v);
                    for (int d = 0; d < 3; d++) check("digit_le9", 32'(bcd[4*d +: 4] <= 4'd9), 1);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready && !rst) ok = 1'b1;
        end
        check("accept", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        bin      = v;
        wait_ready();
        in_valid = 1'b0;
        bin      = 8'($urandom);
    endtask

    task automatic wait_out();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("out_valid_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && in_ready) idle = 1'b1;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        bin       = '0;
        use_rand  = 1'b0;
        ready_fix = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bcd", bcd, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // 255: busy for exactly 8 cycles, then result and handshake
        send(8'd255);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy_shift", busy, 1);
            check("in_ready_shift", in_ready, 0);
        end
        @(negedge clk);
        check("busy_done", busy, 0);
        check("out_valid_done", out_valid, 1);
        @(negedge clk);
        check("in_ready_after_hs", in_ready, 1);
        check("out_valid_after_hs", out_valid, 0);
        @(posedge clk);
        #1;
        drain();

        send(8'd0);
        drain();
        send(8'd99);
        drain();

        // Backpressure: 42 must wait until 137 has been taken
        ready_fix = 1'b0;
        send(8'd137);
        wait_out();
        in_valid = 1'b1;
        bin      = 8'd42;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_bcd", bcd, 12'h137);
        end
        @(posedge clk);
        #1;
        ready_fix = 1'b1;
        send(8'd42);
        drain();

        // Reset during the third shift cycle discards the operand
        send(8'd200);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_bcd", bcd, 0);
        check("abort_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'd128);
        drain();

        // Back-to-back with in_valid held high
        rise_q.delete();
        in_valid = 1'b1;
        bin      = 8'd10;
        wait_ready();
        bin = 8'd200;
        wait_ready();
        in_valid = 1'b0;
        drain();
        check("pulse_count", rise_q.size(), 2);
        if (rise_q.size() == 2) check("pulse_gap", rise_q[1] - rise_q[0], 10);

        // Full sweep with random output stalls
        use_rand = 1'b1;
        for (int v = 0; v < 256; v++) send(8'(v));
        drain();
        use_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
